// File: rtl/block_pkg.sv
// Shared definitions for the block rasteriser: screen size defaults, palette
// constants and the controller state encoding.
package block_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/block_offset_counter.sv
// dx/dy raster counter for a square block: dx wraps at size-1 and carries into
// dy; exposes the next offsets and a flag for the final pixel.
module block_offset_counter
  import block_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_advance,
  input  logic [3:0] i_size,
  output logic [3:0] o_dx_next,
  output logic [3:0] o_dy_next,
  output logic       o_last
);

  logic [3:0] r_dx;
  logic [3:0] r_dy;
  logic       w_wrap;

  assign w_wrap    = (r_dx == i_size - 4'd1);
  assign o_dx_next = w_wrap ? 4'd0 : r_dx + 4'd1;
  assign o_dy_next = w_wrap ? r_dy + 4'd1 : r_dy;
  assign o_last    = w_wrap && (r_dy == i_size - 4'd1);

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_dx <= 4'd0;
      r_dy <= 4'd0;
    end else if (i_advance) begin
      r_dx <= o_dx_next;
      r_dy <= o_dy_next;
    end
  end

endmodule

// File: rtl/block_raster.sv
// Rasterises one square block request into per-pixel VGA writes.
// Optional hollow-outline mode is enabled with the BLOCK_OUTLINE_EN macro.
module block_raster
  import block_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] start_x,
  input  logic [6:0] start_y,
  input  logic [2:0] colour,
  input  logic [3:0] block_size,
`ifdef BLOCK_OUTLINE_EN
  input  logic       outline,
`endif
  output logic       ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       finished
);

  localparam logic [8:0] LIM_X = 9'(SCREEN_W);
  localparam logic [7:0] LIM_Y = 8'(SCREEN_H);

  state_t     r_state;
  logic [7:0] r_base_x;
  logic [6:0] r_base_y;
  logic [2:0] r_colour;
  logic [3:0] r_size;
  logic       r_ready;
  logic       r_plot;
  logic       r_finished;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour_out;

  logic       w_accept;
  logic       w_advance;
  logic [3:0] w_dx_next;
  logic [3:0] w_dy_next;
  logic       w_last;
  logic [7:0] w_bx;
  logic [6:0] w_by;
  logic [3:0] w_dx;
  logic [3:0] w_dy;
  logic [2:0] w_col;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic       w_visible;
  logic       w_plot_next;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_advance = (r_state == DRAW) && !w_last;

  block_offset_counter u_offset (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_advance (w_advance),
    .i_size    (r_size),
    .o_dx_next (w_dx_next),
    .o_dy_next (w_dy_next),
    .o_last    (w_last)
  );

  // On accept the first pixel comes straight from the request inputs so it is
  // registered at the same edge the request is latched.
  assign w_bx  = w_accept ? start_x : r_base_x;
  assign w_by  = w_accept ? start_y : r_base_y;
  assign w_col = w_accept ? colour  : r_colour;
  assign w_dx  = w_accept ? 4'd0    : w_dx_next;
  assign w_dy  = w_accept ? 4'd0    : w_dy_next;

  assign w_sum_x   = {1'b0, w_bx} + {5'd0, w_dx};
  assign w_sum_y   = {1'b0, w_by} + {4'd0, w_dy};
  assign w_visible = (w_sum_x < LIM_X) && (w_sum_y < LIM_Y);

`ifdef BLOCK_OUTLINE_EN
  logic       r_outline;
  logic       w_ol;
  logic [3:0] w_sz;
  logic       w_rim;

  assign w_ol  = w_accept ? outline : r_outline;
  assign w_sz  = w_accept ? block_size : r_size;
  assign w_rim = (w_dx == 4'd0) || (w_dx == w_sz - 4'd1) ||
                 (w_dy == 4'd0) || (w_dy == w_sz - 4'd1);
  assign w_plot_next = w_visible && (!w_ol || w_rim);

  always_ff @(posedge clock) begin
    if (reset) r_outline <= 1'b0;
    else if (w_accept) r_outline <= outline;
  end
`else
  assign w_plot_next = w_visible;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_plot       <= 1'b0;
      r_finished   <= 1'b0;
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_colour_out <= 3'd0;
      r_base_x     <= 8'd0;
      r_base_y     <= 7'd0;
      r_colour     <= 3'd0;
      r_size       <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_plot     <= 1'b0;
          r_finished <= 1'b0;
          if (start) begin
            r_base_x <= start_x;
            r_base_y <= start_y;
            r_colour <= colour;
            r_size   <= block_size;
            r_ready  <= 1'b0;
            if (block_size == 4'd0) begin
              r_state    <= DONE;
              r_finished <= 1'b1;
            end else begin
              r_state      <= DRAW;
              r_x          <= w_sum_x[7:0];
              r_y          <= w_sum_y[6:0];
              r_colour_out <= w_col;
              r_plot       <= w_plot_next;
            end
          end
        end
        DRAW: begin
          if (w_last) begin
            r_state    <= DONE;
            r_plot     <= 1'b0;
            r_finished <= 1'b1;
          end else begin
            r_x          <= w_sum_x[7:0];
            r_y          <= w_sum_y[6:0];
            r_colour_out <= w_col;
            r_plot       <= w_plot_next;
          end
        end
        DONE: begin
          r_finished <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready      = r_ready;
  assign x          = r_x;
  assign y          = r_y;
  assign colour_out = r_colour_out;
  assign plot       = r_plot;
  assign finished   = r_finished;

endmodule

// File: tb/tb_block_raster.sv
// Self-checking bench for block_raster; exercises the outline mode only when
// BLOCK_OUTLINE_EN is defined.
module tb_block_raster;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] start_x;
  logic [6:0] start_y;
  logic [2:0] colour;
  logic [3:0] block_size;
  logic       outline;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_out;
  logic       plot;
  logic       finished;

  int n_cmp = 0;
  int n_err = 0;

  block_raster dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_x    (start_x),
    .start_y    (start_y),
    .colour     (colour),
    .block_size (block_size),
`ifdef BLOCK_OUTLINE_EN
    .outline    (outline),
`endif
    .ready      (ready),
    .x          (x),
    .y          (y),
    .colour_out (colour_out),
    .plot       (plot),
    .finished   (finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  // Issues one request, then checks every following cycle against a model
  // built from plain pixel arithmetic. poke=1 drives a conflicting start
  // during the draw, which must be ignored.
  task automatic run_block(input int sx, input int sy, input int col, input int n,
                           input int ol, input int poke, output int plotted);
    int waitc;
    int px;
    int py;
    int dx;
    int dy;
    logic exp_pl;
    plotted = 0;
    waitc = 0;
    while (ready !== 1'b1 && waitc < 1000) begin
      @(posedge clock); #1;
      waitc++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: ready=%b need 1", ready);
      return;
    end
    start = 1'b1;
    start_x = 8'(sx);
    start_y = 7'(sy);
    colour = 3'(col);
    block_size = 4'(n);
    outline = 1'(ol);
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < n * n; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      if (poke != 0 && k == 1) begin
        start = 1'b1;
        start_x = 8'd0;
        start_y = 7'd0;
        colour = ~3'(col);
        block_size = 4'd1;
        outline = ~1'(ol);
      end
      if (poke != 0 && k == 4) start = 1'b0;
      dx = k % n;
      dy = k / n;
      px = sx + dx;
      py = sy + dy;
      exp_pl = (px < 160) && (py < 120);
      if (ol != 0 && !(dx == 0 || dx == n - 1 || dy == 0 || dy == n - 1)) exp_pl = 1'b0;
      if (plot === 1'b1) plotted++;
      n_cmp++;
      if (plot !== exp_pl || finished !== 1'b0 || ready !== 1'b0) begin
        n_err++;
        $display("FAIL draw_ctl k=%0d: plot/fin/rdy=%b%b%b need %b00", k, plot, finished, ready, exp_pl);
      end
      if (exp_pl) begin
        n_cmp++;
        if (x !== 8'(px) || y !== 7'(py) || colour_out !== 3'(col)) begin
          n_err++;
          $display("FAIL draw_pix k=%0d: got (%0d,%0d,c%0d) need (%0d,%0d,c%0d)", k, x, y, colour_out, px, py, col);
        end
      end
    end
    if (n > 0) begin
      @(posedge clock); #1;
    end
    n_cmp++;
    if (finished !== 1'b1 || plot !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL done: fin/plot/rdy=%b%b%b need 100", finished, plot, ready);
    end
    if (n > 0) begin
      n_cmp++;
      if (x !== 8'(sx + n - 1) || y !== 7'(sy + n - 1)) begin
        n_err++;
        $display("FAIL hold_xy: got (%0d,%0d) need (%0d,%0d)", x, y, (sx + n - 1) % 256, (sy + n - 1) % 128);
      end
    end
    @(posedge clock); #1;
    n_cmp++;
    if (finished !== 1'b0 || plot !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL after_done: fin/plot/rdy=%b%b%b need 001", finished, plot, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (ready !== 1'b1 || plot !== 1'b0 || finished !== 1'b0 ||
        x !== 8'd0 || y !== 7'd0 || colour_out !== 3'd0) begin
      n_err++;
      $display("FAIL reset: rdy=%b plot=%b fin=%b x=%0d y=%0d c=%0d need 1 0 0 0 0 0",
               ready, plot, finished, x, y, colour_out);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int p;
    run_block(10, 20, 7, 2, 0, 0, p);
    n_cmp++;
    if (p != 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d need 4", p);
    end
  endtask

  task automatic test_zero_size();
    int p;
    run_block(30, 40, 5, 0, 0, 0, p);
  endtask

  task automatic test_clip();
    int p;
    run_block(150, 110, 3, 15, 0, 0, p);
    n_cmp++;
    if (p != 100) begin
      n_err++;
      $display("FAIL clip_count: got %0d need 100", p);
    end
  endtask

  task automatic test_busy_ignore();
    int p;
    run_block(40, 30, 2, 4, 0, 1, p);
    n_cmp++;
    if (p != 16) begin
      n_err++;
      $display("FAIL busy_count: got %0d need 16", p);
    end
  endtask

  task automatic test_reset_mid_draw();
    int p;
    start = 1'b1;
    start_x = 8'd5;
    start_y = 7'd6;
    colour = 3'd4;
    block_size = 4'd3;
    outline = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    n_cmp++;
    if (plot !== 1'b1 || x !== 8'd6 || y !== 7'd7) begin
      n_err++;
      $display("FAIL mid_pixel5: plot=%b (%0d,%0d) need 1 (6,7)", plot, x, y);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if (plot !== 1'b0 || ready !== 1'b1 || finished !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: plot/rdy/fin=%b%b%b need 010", plot, ready, finished);
    end
    repeat (3) begin
      @(posedge clock); #1;
      n_cmp++;
      if (finished !== 1'b0 || plot !== 1'b0 || ready !== 1'b1) begin
        n_err++;
        $display("FAIL mid_idle: fin/plot/rdy=%b%b%b need 001", finished, plot, ready);
      end
    end
    run_block(20, 30, 6, 3, 0, 0, p);
  endtask

  task automatic test_start_with_reset();
    start = 1'b1;
    block_size = 4'd2;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (ready !== 1'b1 || plot !== 1'b0 || finished !== 1'b0) begin
      n_err++;
      $display("FAIL start_reset: rdy/plot/fin=%b%b%b need 100", ready, plot, finished);
    end
  endtask

`ifdef BLOCK_OUTLINE_EN
  task automatic test_outline();
    int p;
    run_block(0, 0, 1, 4, 1, 0, p);
    n_cmp++;
    if (p != 12) begin
      n_err++;
      $display("FAIL outline_count: got %0d need 12", p);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int p;
    int ol;
    for (int i = 0; i < 25; i++) begin
      ol = 0;
`ifdef BLOCK_OUTLINE_EN
      ol = int'($urandom_range(0, 1));
`endif
      run_block(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), ol, 0, p);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_x = 8'd0;
    start_y = 7'd0;
    colour = 3'd0;
    block_size = 4'd0;
    outline = 1'b0;
    test_reset();
    test_basic();
    test_zero_size();
    test_clip();
    test_busy_ignore();
    test_reset_mid_draw();
    test_start_with_reset();
`ifdef BLOCK_OUTLINE_EN
    test_outline();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
